// File: rtl/lemming_tracker_pkg.sv
// Shared definitions for the lemming tracker: state encoding, default
// playfield constants and the walker-input legality helper.
package lemming_tracker_pkg;

  // Tracker state; the encoding is shared with integration-level code.
  typedef enum logic [1:0] {
    ST_WALK = 2'b00,
    ST_FALL = 2'b01,
    ST_DEAD = 2'b10
  } lt_state_t;

  // Default playfield geometry and fall threshold.
  localparam int DEF_X_MAX      = 200;
  localparam int DEF_X_INIT     = 100;
  localparam int DEF_FALL_LIMIT = 20;

  // Walker outputs are legal only when exactly one of the three is high.
  function automatic logic is_one_hot3(input logic a, input logic b, input logic c);
    logic r;
    r = (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
    return r;
  endfunction

endpackage : lemming_tracker_pkg

// File: rtl/lemming_tracker.sv
// Lemming tracker: follows the walker FSM's one-hot state outputs, keeps the
// horizontal position inside [0, X_MAX], times falls, decides survival or
// splat, and reports wall contact back to the walker combinationally.
module lemming_tracker
  import lemming_tracker_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int X_INIT     = DEF_X_INIT,
  parameter int FALL_W     = 5,
  parameter int FALL_LIMIT = DEF_FALL_LIMIT
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              walk_left,
  input  logic              walk_right,
  input  logic              aaah,
  output logic [POS_W-1:0]  pos_x,
  output logic [FALL_W-1:0] fall_cnt,
  output logic              hit_left_wall,
  output logic              hit_right_wall,
  output logic              splat,
  output logic [7:0]        safe_falls,
  output logic              err
);

  localparam logic [POS_W-1:0]  L_POS_ZERO   = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]  L_POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  L_X_MAX      = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]  L_X_INIT     = POS_W'(X_INIT);
  localparam logic [FALL_W-1:0] L_FALL_ZERO  = {FALL_W{1'b0}};
  localparam logic [FALL_W-1:0] L_FALL_ONE   = {{(FALL_W-1){1'b0}}, 1'b1};
  localparam logic [FALL_W-1:0] L_FALL_MAX   = {FALL_W{1'b1}};
  localparam logic [FALL_W-1:0] L_FALL_LIMIT = FALL_W'(FALL_LIMIT);
  localparam logic [7:0]        L_SAFE_MAX   = 8'hFF;

  lt_state_t         r_state;
  logic [POS_W-1:0]  r_pos_x;
  logic [FALL_W-1:0] r_fall_cnt;
  logic              r_splat;
  logic [7:0]        r_safe_falls;
  logic              r_err;

  lt_state_t         w_state_nxt;
  logic [POS_W-1:0]  w_pos_x_nxt;
  logic [FALL_W-1:0] w_fall_cnt_nxt;
  logic              w_splat_nxt;
  logic [7:0]        w_safe_falls_nxt;
  logic              w_err_nxt;
  logic              w_legal;

  assign w_legal = is_one_hot3(walk_left, walk_right, aaah);

  // State and tracked quantities; asynchronous reset returns to the spawn point.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_WALK;
      r_pos_x      <= L_X_INIT;
      r_fall_cnt   <= L_FALL_ZERO;
      r_splat      <= 1'b0;
      r_safe_falls <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos_x      <= w_pos_x_nxt;
      r_fall_cnt   <= w_fall_cnt_nxt;
      r_splat      <= w_splat_nxt;
      r_safe_falls <= w_safe_falls_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state logic; an illegal input combination is a pure hold cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_pos_x_nxt      = r_pos_x;
    w_fall_cnt_nxt   = r_fall_cnt;
    w_splat_nxt      = r_splat;
    w_safe_falls_nxt = r_safe_falls;
    w_err_nxt        = r_err | ~w_legal;
    if (!w_legal) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        ST_WALK: begin
          if (aaah) begin
            w_state_nxt    = ST_FALL;
            w_fall_cnt_nxt = L_FALL_ONE;
          end else if (walk_left) begin
            if (r_pos_x != L_POS_ZERO) begin
              w_pos_x_nxt = r_pos_x - L_POS_ONE;
            end else begin
              w_pos_x_nxt = r_pos_x;
            end
          end else begin
            if (r_pos_x < L_X_MAX) begin
              w_pos_x_nxt = r_pos_x + L_POS_ONE;
            end else begin
              w_pos_x_nxt = r_pos_x;
            end
          end
        end
        ST_FALL: begin
          if (aaah) begin
            if (r_fall_cnt != L_FALL_MAX) begin
              w_fall_cnt_nxt = r_fall_cnt + L_FALL_ONE;
            end else begin
              w_fall_cnt_nxt = r_fall_cnt;
            end
          end else if (r_fall_cnt > L_FALL_LIMIT) begin
            // Fatal landing: fall_cnt is kept as the record of the fall.
            w_state_nxt = ST_DEAD;
            w_splat_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_WALK;
            w_fall_cnt_nxt = L_FALL_ZERO;
            if (r_safe_falls != L_SAFE_MAX) begin
              w_safe_falls_nxt = r_safe_falls + 8'd1;
            end else begin
              w_safe_falls_nxt = r_safe_falls;
            end
          end
        end
        ST_DEAD: begin
          w_state_nxt = ST_DEAD;
        end
        default: begin
          // Unreachable encoding: park in DEAD so the fault is visible.
          w_state_nxt = ST_DEAD;
        end
      endcase
    end
  end

  // Wall contact is same-cycle so the walker turns on its next edge.
  always_comb begin
    hit_left_wall  = (r_state == ST_WALK) & walk_left  & (r_pos_x == L_POS_ZERO);
    hit_right_wall = (r_state == ST_WALK) & walk_right & (r_pos_x == L_X_MAX);
  end

  assign pos_x      = r_pos_x;
  assign fall_cnt   = r_fall_cnt;
  assign splat      = r_splat;
  assign safe_falls = r_safe_falls;
  assign err        = r_err;

endmodule : lemming_tracker

// File: tb/tb_lemming_tracker.sv
// Self-checking bench for lemming_tracker: a behavioural model of the
// lemming's life is compared against the DUT on every falling edge, and
// directed scenarios carry hand-computed literal expectations.
module tb_lemming_tracker;

  logic       clk;
  logic       areset;
  logic       walk_left;
  logic       walk_right;
  logic       aaah;
  logic [7:0] pos_x;
  logic [4:0] fall_cnt;
  logic       hit_left_wall;
  logic       hit_right_wall;
  logic       splat;
  logic [7:0] safe_falls;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  lemming_tracker dut (
    .clk            (clk),
    .areset         (areset),
    .walk_left      (walk_left),
    .walk_right     (walk_right),
    .aaah           (aaah),
    .pos_x          (pos_x),
    .fall_cnt       (fall_cnt),
    .hit_left_wall  (hit_left_wall),
    .hit_right_wall (hit_right_wall),
    .splat          (splat),
    .safe_falls     (safe_falls),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the lemming: 0 = walking, 1 = falling, 2 = dead.
  typedef struct {
    int st;
    int pos;
    int fc;
    int splat;
    int safe;
    int err;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_reset();
    mdl_t r;
    r.st = 0; r.pos = 100; r.fc = 0; r.splat = 0; r.safe = 0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t model_next(mdl_t c, int wl, int wr, int ah);
    mdl_t n;
    n = c;
    if (wl + wr + ah != 1) begin
      n.err = 1;
      return n;
    end
    if (c.st == 0) begin
      if (ah == 1) begin
        n.st = 1;
        n.fc = 1;
      end else if (wl == 1) begin
        n.pos = (c.pos > 0) ? c.pos - 1 : 0;
      end else begin
        n.pos = (c.pos < 200) ? c.pos + 1 : 200;
      end
    end else if (c.st == 1) begin
      if (ah == 1) begin
        n.fc = (c.fc < 31) ? c.fc + 1 : 31;
      end else if (c.fc > 20) begin
        n.st = 2;
        n.splat = 1;
      end else begin
        n.st = 0;
        n.fc = 0;
        n.safe = (c.safe < 255) ? c.safe + 1 : 255;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m <= model_reset();
    end else begin
      m <= model_next(m, int'(walk_left), int'(walk_right), int'(aaah));
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("pos_x", int'(pos_x), m.pos);
    chk("fall_cnt", int'(fall_cnt), m.fc);
    chk("splat", int'(splat), m.splat);
    chk("safe_falls", int'(safe_falls), m.safe);
    chk("err", int'(err), m.err);
    chk("hit_left_wall", int'(hit_left_wall),
        (m.st == 0 && walk_left && m.pos == 0) ? 1 : 0);
    chk("hit_right_wall", int'(hit_right_wall),
        (m.st == 0 && walk_right && m.pos == 200) ? 1 : 0);
  end

  // Apply an input pattern for n rising edges; returns 2 units after the last.
  task automatic drive(input logic wl, input logic wr, input logic ah, input int n);
    walk_left  = wl;
    walk_right = wr;
    aaah       = ah;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic wl, input logic wr, input logic ah);
    walk_left  = wl;
    walk_right = wr;
    aaah       = ah;
    #1;
  endtask

  task automatic async_reset();
    #4;
    areset = 1'b1;
    #1;
    chk("rst_pos_x", int'(pos_x), 100);
    chk("rst_fall_cnt", int'(fall_cnt), 0);
    chk("rst_splat", int'(splat), 0);
    chk("rst_safe", int'(safe_falls), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk);
    #2;
    areset = 1'b0;
  endtask

  initial begin
    areset     = 1'b1;
    walk_left  = 1'b0;
    walk_right = 1'b1;
    aaah       = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("init_pos_x", int'(pos_x), 100);
    chk("init_fall_cnt", int'(fall_cnt), 0);
    chk("init_safe", int'(safe_falls), 0);
    areset = 1'b0;

    // Walk right five steps.
    drive(1'b0, 1'b1, 1'b0, 5);
    chk("walk5_pos", int'(pos_x), 105);
    chk("walk5_hit_r", int'(hit_right_wall), 0);
    chk("walk5_err", int'(err), 0);

    // Walk to the left wall and press against it.
    drive(1'b1, 1'b0, 1'b0, 105);
    chk("left_pos", int'(pos_x), 0);
    set_in(1'b1, 1'b0, 1'b0);
    chk("left_hit", int'(hit_left_wall), 1);
    drive(1'b1, 1'b0, 1'b0, 1);
    chk("left_hold", int'(pos_x), 0);

    // Walk to the right wall and press against it.
    drive(1'b0, 1'b1, 1'b0, 200);
    chk("right_pos", int'(pos_x), 200);
    set_in(1'b0, 1'b1, 1'b0);
    chk("right_hit", int'(hit_right_wall), 1);
    drive(1'b0, 1'b1, 1'b0, 1);
    chk("right_hold", int'(pos_x), 200);

    // Longest survivable fall, landing toward the wall.
    drive(1'b0, 1'b0, 1'b1, 20);
    chk("fall20_cnt", int'(fall_cnt), 20);
    set_in(1'b0, 1'b1, 1'b0);
    chk("land_no_hit", int'(hit_right_wall), 0);
    drive(1'b0, 1'b1, 1'b0, 1);
    chk("land_safe", int'(safe_falls), 1);
    chk("land_splat", int'(splat), 0);
    chk("land_fc", int'(fall_cnt), 0);
    chk("land_pos", int'(pos_x), 200);
    set_in(1'b0, 1'b1, 1'b0);
    chk("walk_again_hit", int'(hit_right_wall), 1);

    // Illegal input is a sticky error and a hold cycle.
    drive(1'b1, 1'b0, 1'b0, 3);
    chk("back3_pos", int'(pos_x), 197);
    drive(1'b1, 1'b0, 1'b1, 1);
    chk("err_set", int'(err), 1);
    chk("err_pos", int'(pos_x), 197);
    chk("err_fc", int'(fall_cnt), 0);
    drive(1'b1, 1'b0, 1'b0, 1);
    chk("err_sticky", int'(err), 1);
    chk("err_walk", int'(pos_x), 196);

    // Fall of 21 cycles is fatal.
    drive(1'b0, 1'b0, 1'b1, 21);
    chk("fall21_cnt", int'(fall_cnt), 21);
    drive(1'b1, 1'b0, 1'b0, 1);
    chk("splat21", int'(splat), 1);
    drive(1'b1, 1'b0, 1'b0, 3);
    chk("dead_pos", int'(pos_x), 196);
    chk("dead_fc", int'(fall_cnt), 21);
    chk("dead_safe", int'(safe_falls), 1);
    async_reset();

    // Long fall saturates the counter.
    drive(1'b0, 1'b0, 1'b1, 40);
    chk("sat_cnt", int'(fall_cnt), 31);
    drive(1'b1, 1'b0, 1'b0, 1);
    chk("sat_splat", int'(splat), 1);
    async_reset();

    // Zero-hot input mid-fall holds the counter; reset mid-fall.
    drive(1'b0, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b0, 2);
    chk("hold_fc", int'(fall_cnt), 3);
    chk("hold_err", int'(err), 1);
    drive(1'b0, 1'b0, 1'b1, 1);
    chk("resume_fc", int'(fall_cnt), 4);
    async_reset();
    drive(1'b1, 1'b0, 1'b0, 1);
    chk("post_rst_walk", int'(pos_x), 99);
    chk("post_rst_fc", int'(fall_cnt), 0);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_lemming_tracker
